// File: rtl/chess_pkg.sv
// Shared chess definitions: piece codes, colour helper, controller states
// and the start position used to reset the board.
package chess_pkg;

    typedef logic [3:0] piece_t;

    // White pieces use codes 0-5 and black pieces use codes 6-11.
    localparam piece_t W_ROOK   = 4'd0;
    localparam piece_t W_KNIGHT = 4'd1;
    localparam piece_t W_BISHOP = 4'd2;
    localparam piece_t W_QUEEN  = 4'd3;
    localparam piece_t W_KING   = 4'd4;
    localparam piece_t W_PAWN   = 4'd5;
    localparam piece_t B_ROOK   = 4'd6;
    localparam piece_t B_KNIGHT = 4'd7;
    localparam piece_t B_BISHOP = 4'd8;
    localparam piece_t B_QUEEN  = 4'd9;
    localparam piece_t B_KING   = 4'd10;
    localparam piece_t B_PAWN   = 4'd11;
    localparam piece_t EMPTY    = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SRC_HELD = 2'd1,
        ST_CHECK    = 2'd2,
        ST_HALT     = 2'd3
    } ctrl_state_t;

    typedef enum logic [1:0] {
        COLOR_WHITE = 2'd0,
        COLOR_BLACK = 2'd1,
        COLOR_NONE  = 2'd2
    } color_t;

    // Codes 12-15 belong to nobody; 15 is the empty square.
    function automatic color_t piece_color(input piece_t code);
        if (code <= W_PAWN)
            return COLOR_WHITE;
        else if (code <= B_PAWN)
            return COLOR_BLACK;
        else
            return COLOR_NONE;
    endfunction

    function automatic logic is_king(input piece_t code);
        return (code == W_KING) || (code == B_KING);
    endfunction

    // Indexed [y][x]; black occupies rows 0-1, white rows 6-7.
    localparam piece_t START_BOARD [8][8] = '{
        '{B_ROOK, B_KNIGHT, B_BISHOP, B_QUEEN, B_KING, B_BISHOP, B_KNIGHT, B_ROOK},
        '{B_PAWN, B_PAWN, B_PAWN, B_PAWN, B_PAWN, B_PAWN, B_PAWN, B_PAWN},
        '{EMPTY, EMPTY, EMPTY, EMPTY, EMPTY, EMPTY, EMPTY, EMPTY},
        '{EMPTY, EMPTY, EMPTY, EMPTY, EMPTY, EMPTY, EMPTY, EMPTY},
        '{EMPTY, EMPTY, EMPTY, EMPTY, EMPTY, EMPTY, EMPTY, EMPTY},
        '{EMPTY, EMPTY, EMPTY, EMPTY, EMPTY, EMPTY, EMPTY, EMPTY},
        '{W_PAWN, W_PAWN, W_PAWN, W_PAWN, W_PAWN, W_PAWN, W_PAWN, W_PAWN},
        '{W_ROOK, W_KNIGHT, W_BISHOP, W_QUEEN, W_KING, W_BISHOP, W_KNIGHT, W_ROOK}
    };

endpackage

// File: rtl/board_state_reg.sv
// Authoritative 8x8 board. One commit port moves a piece: the destination
// takes the piece and the source becomes empty in the same clock edge.
// The code currently at the destination is reported so the caller can see
// what a commit is about to capture.
module board_state_reg
    import chess_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   commit_en,
    input  logic [2:0] src_x,
    input  logic [2:0] src_y,
    input  logic [2:0] dst_x,
    input  logic [2:0] dst_y,
    input  piece_t commit_piece,
    output piece_t board [8][8],
    output piece_t dst_piece
);

    piece_t board_reg [8][8];

    // Reset to the start position; a commit writes both squares at once,
    // with the destination write winning if the squares ever coincide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int y = 0; y < 8; y++) begin
                for (int x = 0; x < 8; x++) begin
                    board_reg[y][x] <= START_BOARD[y][x];
                end
            end
        end else if (commit_en) begin
            board_reg[src_y][src_x] <= EMPTY;
            board_reg[dst_y][dst_x] <= commit_piece;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_row
            assign board[gi] = board_reg[gi];
        end
    endgenerate

    assign dst_piece = board_reg[dst_y][dst_x];

endmodule

// File: rtl/move_controller.sv
// Move-check initiator: turns cursor selects into source/destination pairs,
// asks the external validator for a verdict and commits or rejects the move.
// Build option: define TURN_ENFORCE_EN to restrict sources to the side to move;
// without it any piece may be picked up and turn is kept for display only.
module move_controller
    import chess_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       sel_valid,
    input  logic [2:0] sel_x,
    input  logic [2:0] sel_y,
    input  logic       cancel,
    output logic [2:0] req_old_x,
    output logic [2:0] req_old_y,
    output logic [2:0] req_new_x,
    output logic [2:0] req_new_y,
    output logic [3:0] req_piece,
    output logic       req_valid,
    input  logic       rsp_valid,
    input  logic       rsp_move_ok,
    output piece_t     board_out [8][8],
    output logic       turn,
    output logic       src_held,
    output logic [2:0] src_x,
    output logic [2:0] src_y,
    output logic       move_done,
    output logic       move_rej,
    output logic       game_over
);

    ctrl_state_t state_reg;
    logic [2:0]  src_x_reg, src_y_reg, dst_x_reg, dst_y_reg;
    piece_t      src_piece_reg;
    logic [2:0]  req_old_x_reg, req_old_y_reg, req_new_x_reg, req_new_y_reg;
    piece_t      req_piece_reg;
    logic        turn_reg, src_held_reg;
    logic        move_done_reg, move_rej_reg, game_over_reg;

    piece_t      sel_piece;
    piece_t      dst_piece;
    logic        commit_en;
    logic        sel_is_source;
    logic        sel_is_own;

    board_state_reg u_board (
        .clk          (clk),
        .reset        (reset),
        .commit_en    (commit_en),
        .src_x        (src_x_reg),
        .src_y        (src_y_reg),
        .dst_x        (dst_x_reg),
        .dst_y        (dst_y_reg),
        .commit_piece (src_piece_reg),
        .board        (board_out),
        .dst_piece    (dst_piece)
    );

    assign sel_piece = board_out[sel_y][sel_x];

`ifdef TURN_ENFORCE_EN
    color_t turn_color;
    assign turn_color    = turn_reg ? COLOR_BLACK : COLOR_WHITE;
    // Only the side to move may pick up a piece; its own pieces block a move.
    assign sel_is_source = (piece_color(sel_piece) == turn_color);
    assign sel_is_own    = sel_is_source;
`else
    // Any piece may be picked up; the destination is "own" when it shares
    // the colour of the held piece.
    assign sel_is_source = (piece_color(sel_piece) != COLOR_NONE);
    assign sel_is_own    = (piece_color(sel_piece) == piece_color(src_piece_reg));
`endif

    assign commit_en = (state_reg == ST_CHECK) && rsp_valid && rsp_move_ok;

    // Select/validate/commit sequencing with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            src_x_reg     <= 3'd0;
            src_y_reg     <= 3'd0;
            dst_x_reg     <= 3'd0;
            dst_y_reg     <= 3'd0;
            src_piece_reg <= EMPTY;
            req_old_x_reg <= 3'd0;
            req_old_y_reg <= 3'd0;
            req_new_x_reg <= 3'd0;
            req_new_y_reg <= 3'd0;
            req_piece_reg <= 4'd0;
            turn_reg      <= 1'b0;
            src_held_reg  <= 1'b0;
            move_done_reg <= 1'b0;
            move_rej_reg  <= 1'b0;
            game_over_reg <= 1'b0;
        end else begin
            move_done_reg <= 1'b0;
            move_rej_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (sel_valid && sel_is_source) begin
                        src_x_reg     <= sel_x;
                        src_y_reg     <= sel_y;
                        src_piece_reg <= sel_piece;
                        src_held_reg  <= 1'b1;
                        state_reg     <= ST_SRC_HELD;
                    end
                end
                ST_SRC_HELD: begin
                    if (cancel) begin
                        src_held_reg <= 1'b0;
                        state_reg    <= ST_IDLE;
                    end else if (sel_valid) begin
                        if (sel_x == src_x_reg && sel_y == src_y_reg) begin
                            src_held_reg <= 1'b0;
                            state_reg    <= ST_IDLE;
                        end else if (sel_is_own) begin
                            src_x_reg     <= sel_x;
                            src_y_reg     <= sel_y;
                            src_piece_reg <= sel_piece;
                        end else begin
                            dst_x_reg     <= sel_x;
                            dst_y_reg     <= sel_y;
                            req_old_x_reg <= src_x_reg;
                            req_old_y_reg <= src_y_reg;
                            req_new_x_reg <= sel_x;
                            req_new_y_reg <= sel_y;
                            req_piece_reg <= src_piece_reg;
                            state_reg     <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (rsp_valid) begin
                        req_old_x_reg <= 3'd0;
                        req_old_y_reg <= 3'd0;
                        req_new_x_reg <= 3'd0;
                        req_new_y_reg <= 3'd0;
                        req_piece_reg <= 4'd0;
                        src_held_reg  <= 1'b0;
                        if (rsp_move_ok) begin
                            move_done_reg <= 1'b1;
                            turn_reg      <= ~turn_reg;
                            if (is_king(dst_piece)) begin
                                game_over_reg <= 1'b1;
                                state_reg     <= ST_HALT;
                            end else begin
                                state_reg <= ST_IDLE;
                            end
                        end else begin
                            move_rej_reg <= 1'b1;
                            state_reg    <= ST_IDLE;
                        end
                    end
                end
                ST_HALT: begin
                    state_reg <= ST_HALT;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_valid = (state_reg == ST_CHECK);
    assign req_old_x = req_old_x_reg;
    assign req_old_y = req_old_y_reg;
    assign req_new_x = req_new_x_reg;
    assign req_new_y = req_new_y_reg;
    assign req_piece = req_piece_reg;
    assign turn      = turn_reg;
    assign src_held  = src_held_reg;
    assign src_x     = src_x_reg;
    assign src_y     = src_y_reg;
    assign move_done = move_done_reg;
    assign move_rej  = move_rej_reg;
    assign game_over = game_over_reg;

endmodule

// File: tb/tb_move_controller.sv
// Bench for move_controller: the bench plays the validator, pushes expected
// requests and verdict outcomes into queues, and a negedge monitor pops and
// compares them whenever the DUT presents a request or a result pulse.
module tb_move_controller;

    logic       clk;
    logic       reset;
    logic       sel_valid;
    logic [2:0] sel_x, sel_y;
    logic       cancel;
    logic [2:0] req_old_x, req_old_y, req_new_x, req_new_y;
    logic [3:0] req_piece;
    logic       req_valid;
    logic       rsp_valid, rsp_move_ok;
    logic [3:0] board_out [8][8];
    logic       turn, src_held;
    logic [2:0] src_x, src_y;
    logic       move_done, move_rej, game_over;

    typedef logic [7:0][7:0][3:0] brd_t;

    typedef struct packed {
        logic [2:0] ox;
        logic [2:0] oy;
        logic [2:0] nx;
        logic [2:0] ny;
        logic [3:0] piece;
    } req_exp_t;

    typedef struct packed {
        logic done;
        logic turn;
        logic gover;
        brd_t brd;
    } rsp_exp_t;

    req_exp_t req_q [$];
    rsp_exp_t rsp_q [$];

    int   checks;
    int   errors;
    brd_t mboard;
    logic mturn;
    logic mgover;
    logic req_prev;

    move_controller dut (
        .clk         (clk),
        .reset       (reset),
        .sel_valid   (sel_valid),
        .sel_x       (sel_x),
        .sel_y       (sel_y),
        .cancel      (cancel),
        .req_old_x   (req_old_x),
        .req_old_y   (req_old_y),
        .req_new_x   (req_new_x),
        .req_new_y   (req_new_y),
        .req_piece   (req_piece),
        .req_valid   (req_valid),
        .rsp_valid   (rsp_valid),
        .rsp_move_ok (rsp_move_ok),
        .board_out   (board_out),
        .turn        (turn),
        .src_held    (src_held),
        .src_x       (src_x),
        .src_y       (src_y),
        .move_done   (move_done),
        .move_rej    (move_rej),
        .game_over   (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic brd_t start_board();
        brd_t b;
        int   back_w [8];
        int   back_b [8];
        back_w = '{0, 1, 2, 3, 4, 2, 1, 0};
        back_b = '{6, 7, 8, 9, 10, 8, 7, 6};
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                b[y][x] = 4'd15;
            end
        end
        for (int x = 0; x < 8; x++) begin
            b[0][x] = 4'(back_b[x]);
            b[1][x] = 4'd11;
            b[6][x] = 4'd5;
            b[7][x] = 4'(back_w[x]);
        end
        return b;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_board(input string name, input brd_t exp);
        int bad_y;
        int bad_x;
        bad_y = -1;
        bad_x = -1;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                if (board_out[y][x] !== exp[y][x] && bad_y < 0) begin
                    bad_y = y;
                    bad_x = x;
                end
            end
        end
        checks++;
        if (bad_y >= 0) begin
            errors++;
            $display("FAIL %s: square x=%0d y=%0d got %0d expected %0d",
                     name, bad_x, bad_y, board_out[bad_y][bad_x], exp[bad_y][bad_x]);
        end
    endtask

    // Monitor: compare each new request and each result pulse with the queues.
    always @(negedge clk) begin
        req_exp_t re;
        rsp_exp_t se;
        if (req_valid && !req_prev) begin
            $display("req: old=(%0d,%0d) new=(%0d,%0d) piece=%0d",
                     req_old_x, req_old_y, req_new_x, req_new_y, req_piece);
            if (req_q.size() == 0) begin
                chk("req_unexpected", 1, 0);
            end else begin
                re = req_q.pop_front();
                chk("req_fields", {req_old_x, req_old_y, req_new_x, req_new_y, req_piece}, re);
            end
        end
        req_prev = req_valid;
        if (move_done || move_rej) begin
            $display("rsp: done=%0d rej=%0d turn=%0d game_over=%0d",
                     move_done, move_rej, turn, game_over);
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                se = rsp_q.pop_front();
                chk("rsp_kind", {move_done, move_rej}, {se.done, ~se.done});
                chk("rsp_turn", turn, se.turn);
                chk("rsp_game_over", game_over, se.gover);
                chk_board("rsp_board", se.brd);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        mboard = start_board();
        mturn  = 1'b0;
        mgover = 1'b0;
    endtask

    task automatic select(input int x, input int y);
        sel_valid = 1'b1;
        sel_x = 3'(x);
        sel_y = 3'(y);
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    // Full move: source select, destination select, one-cycle verdict.
    task automatic do_move(input int sx, input int sy, input int dx, input int dy, input logic ok);
        rsp_exp_t e;
        logic [3:0] cap;
        select(sx, sy);
        req_q.push_back({3'(sx), 3'(sy), 3'(dx), 3'(dy), mboard[sy][sx]});
        select(dx, dy);
        chk("req_valid_after_dst", req_valid, 1);
        if (ok) begin
            cap = mboard[dy][dx];
            mboard[dy][dx] = mboard[sy][sx];
            mboard[sy][sx] = 4'd15;
            mturn = ~mturn;
            if (cap == 4'd4 || cap == 4'd10) mgover = 1'b1;
        end
        e.done  = ok;
        e.turn  = mturn;
        e.gover = mgover;
        e.brd   = mboard;
        rsp_q.push_back(e);
        rsp_valid   = 1'b1;
        rsp_move_ok = ok;
        tick();
        rsp_valid   = 1'b0;
        rsp_move_ok = 1'b0;
        chk("req_valid_after_rsp", req_valid, 0);
        chk("src_held_after_rsp", src_held, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        req_prev = 1'b0;
        reset = 1'b1;
        sel_valid = 1'b0;
        sel_x = 3'd0;
        sel_y = 3'd0;
        cancel = 1'b0;
        rsp_valid = 1'b0;
        rsp_move_ok = 1'b0;

        // Reset state
        do_reset();
        chk_board("reset_board", start_board());
        chk("reset_white_king", board_out[7][4], 4);
        chk("reset_black_king", board_out[0][4], 10);
        chk("reset_turn", turn, 0);
        chk("reset_src_held", src_held, 0);
        chk("reset_src_xy", {src_x, src_y}, 0);
        chk("reset_req_valid", req_valid, 0);
        chk("reset_req_fields", {req_old_x, req_old_y, req_new_x, req_new_y, req_piece}, 0);
        chk("reset_pulses", {move_done, move_rej, game_over}, 0);

        // Pawn (4,6)->(4,4), accepted
        select(4, 6);
        chk("pawn_src_held", src_held, 1);
        req_q.push_back({3'd4, 3'd6, 3'd4, 3'd4, 4'd5});
        select(4, 4);
        chk("pawn_req_valid", req_valid, 1);
        chk("pawn_req_piece", req_piece, 5);
        mboard[4][4] = 4'd5;
        mboard[6][4] = 4'd15;
        mturn = 1'b1;
        rsp_q.push_back({1'b1, 1'b1, 1'b0, mboard});
        rsp_valid = 1'b1;
        rsp_move_ok = 1'b1;
        tick();
        rsp_valid = 1'b0;
        rsp_move_ok = 1'b0;
        chk("pawn_dst_square", board_out[4][4], 5);
        chk("pawn_src_square", board_out[6][4], 15);
        chk("pawn_turn", turn, 1);
        chk("pawn_done_pulse", move_done, 1);
        tick();
        chk("pawn_done_one_cycle", move_done, 0);

        // Rook (0,7)->(0,4), rejected
        do_reset();
        do_move(0, 7, 0, 4, 1'b0);
        chk("rej_turn", turn, 0);
        chk("rej_rook_stays", board_out[7][0], 0);
        tick();
        chk("rej_pulse_one_cycle", move_rej, 0);

        // Black pawn select while white to move
        select(3, 1);
`ifdef TURN_ENFORCE_EN
        chk("black_pawn_ignored", src_held, 0);
`else
        chk("black_pawn_held", src_held, 1);
        do_cancel();
        chk("black_pawn_cancel", src_held, 0);
`endif

        // Deselect, re-latch, cancel priority
        select(1, 7);
        chk("knight_held", {src_held, src_x, src_y}, {1'b1, 3'd1, 3'd7});
        select(1, 7);
        chk("knight_deselect", src_held, 0);
        select(1, 7);
        select(6, 7);
        chk("relatch_src", {src_held, src_x, src_y}, {1'b1, 3'd6, 3'd7});
        chk("relatch_no_req", req_valid, 0);
        cancel = 1'b1;
        select(1, 5);
        cancel = 1'b0;
        chk("cancel_priority_held", src_held, 0);
        chk("cancel_priority_req", req_valid, 0);

        // Queen captures the black king -> game over
        do_move(3, 7, 3, 3, 1'b1);
        do_move(4, 0, 3, 2, 1'b1);
        do_move(3, 3, 3, 2, 1'b1);
        chk("king_capture_game_over", game_over, 1);
        chk("king_capture_square", board_out[2][3], 3);
        select(0, 0);
        chk("halt_select_ignored", src_held, 0);
        select(1, 0);
        select(2, 2);
        repeat (3) tick();
        chk("halt_no_req", req_valid, 0);
        chk("halt_game_over_sticky", game_over, 1);
        chk_board("halt_board_frozen", mboard);

        // Reset during a stalled check
        do_reset();
        chk("reset_clears_game_over", game_over, 0);
        select(1, 7);
        req_q.push_back({3'd1, 3'd7, 3'd2, 3'd5, 4'd1});
        select(2, 5);
        repeat (20) tick();
        chk("stall_req_held", req_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_req_drop", req_valid, 0);
        chk("async_req_fields", {req_old_x, req_old_y, req_new_x, req_new_y, req_piece}, 0);
        @(negedge clk);
        chk_board("async_board_start", start_board());
        chk("async_turn", turn, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) tick();
        chk("req_queue_drained", req_q.size(), 0);
        chk("rsp_queue_drained", rsp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/move_controller.md
# move_controller

Initiator side of the move-check interface. Turns cursor select events into source/destination square pairs and looks up the moving piece. It issues a check request to the external `board_validator`, waits for its result, then commits or rejects the move. Owns the authoritative 8x8 board state and the side-to-move, and sits between the cursor/input logic and the board renderer.

## Interface
- No parameters; board geometry fixed at 8x8, piece codes 4-bit.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high; one clock; reset is asynchronous and active-high.
- `sel_valid` in 1: one-cycle pulse; the cursor square is selected.
- `sel_x`, `sel_y` in 3 each: cursor square, sampled with `sel_valid`.
- `cancel` in 1: drop the held source square.
- `req_old_x`, `req_old_y`, `req_new_x`, `req_new_y` out 3 each: request coordinates to the validator.
- `req_piece` out 4: piece code at the source square.
- `req_valid` out 1: request valid; drives the validator's `valid_input`.
- `rsp_valid` in 1: validator result present; from the validator's `valid_output`.
- `rsp_move_ok` in 1: validator verdict; from the validator's `valid_move`.
- `board_out` out 4 x [8][8]: board state, indexed `[y][x]`; 15 means empty.
- `turn` out 1: side to move; 0 = white (codes 0-5), 1 = black (codes 6-11).
- `src_held` out 1: a source square is latched.
- `src_x`, `src_y` out 3 each: the latched source, for highlighting.
- `move_done` out 1: one-cycle pulse; a move was committed.
- `move_rej` out 1: one-cycle pulse; the validator rejected the move.
- `game_over` out 1: sticky; a king was captured.

## Operation
- States: IDLE, SRC_HELD, CHECK, HALT.
- Ownership test: a code is own-side if it is 0-5 and `turn`=0, or 6-11 and `turn`=1. Code 15 is never own-side.
- IDLE:
  - `sel_valid` on an own-side piece: latch the source, go to SRC_HELD.
  - `sel_valid` on anything else: ignored.
- SRC_HELD:
  - `cancel`: go to IDLE. `cancel` has priority over `sel_valid` in the same cycle.
  - Select on the same square: deselect, go to IDLE.
  - Select on another own-side piece: re-latch it as the source, stay in SRC_HELD.
  - Any other select: latch the destination, go to CHECK.
- CHECK:
  - `req_valid`=1; the request outputs are held stable from registers.
  - Wait indefinitely for `rsp_valid`. `sel_valid` and `cancel` are ignored.
  - `rsp_valid` and `rsp_move_ok`:
    - Commit: destination gets the piece, source gets 15.
    - Pulse `move_done`.
    - Toggle `turn`.
    - If the captured code was 4 or 10, set `game_over` and go to HALT; otherwise go to IDLE.
  - `rsp_valid` and not `rsp_move_ok`: pulse `move_rej`, board unchanged, go to IDLE.
- HALT: every input is ignored until `reset`.
- `req_*` outputs are 0 outside CHECK.
- Start position:
  - Row 7 = 0,1,2,3,4,2,1,0.
  - Row 6 = all 5.
  - Row 1 = all 11.
  - Row 0 = 6,7,8,9,10,8,7,6.
  - Rows 2-5 = 15.

## Timing
- Reset values: board = start position, `turn`=0, state IDLE, `src_held`=0, `src_x`/`src_y`=0, all `req_*`=0, `move_done`=`move_rej`=`game_over`=0.
- All outputs are registered except `req_valid`, which is decoded from the state register.
- Source select at edge N: `src_held`=1 from cycle N+1.
- Destination select at edge N: `req_valid`=1 from cycle N+1.
- The validator is combinational, so `rsp_valid` normally rises in cycle N+1.
- Result sampled at edge M:
  - The updated `board_out`, the `move_done`/`move_rej` pulse and the toggled `turn` all appear in cycle M+1.
  - State is back in IDLE in cycle M+1.
- With an immediate response, the total is 2 cycles from destination select to committed board.
- `reset` asserted mid-CHECK: the request drops asynchronously, and the board and turn return to the start position.

## Configuration
- `TURN_ENFORCE_EN` defined:
  - The ownership test uses `turn` as above.
  - `turn` toggles on each commit.
- `TURN_ENFORCE_EN` undefined:
  - Any non-empty code is a valid source.
  - The destination is "own" only if it has the same colour as the source.
  - `turn` still toggles on each commit, for display only.

## Structure
- Shared package `chess_pkg`:
  - Piece code constants, with `EMPTY` = 4'd15.
  - A `piece_color()` function.
  - The controller state enum.
  - The start-position constant array.
- One sub-module, `board_state_reg`:
  - Holds the 8x8 array and resets it to the start position.
  - Single commit port: src/dst coordinates, piece code and write enable, doing both square updates in one clock edge.
  - Also reports the code captured at the destination.

## Test plan
- Reset, then select (4,6) and (4,4) with `rsp_move_ok`=1:
  - `req_piece`=5 in CHECK.
  - After commit: `board_out[4][4]`=5, `board_out[6][4]`=15, `turn`=1, one `move_done` pulse.
- Select (0,7) then (0,4) with `rsp_move_ok`=0: one `move_rej` pulse, board unchanged, `turn`=0, state IDLE.
- Reset, then select (3,1) (black pawn) while `turn`=0: no state change, `src_held`=0. With `TURN_ENFORCE_EN` undefined, `src_held`=1.
- Source (1,7):
  - Select (1,7) again: deselect.
  - Select (1,7), then (6,7): source re-latched to (6,7).
  - `cancel` asserted together with `sel_valid`: IDLE.
- Preload a board with white queen at (3,3) and black king at (3,2), then commit (3,3)->(3,2):
  - `game_over`=1.
  - Later selects ignored.
- Hold `rsp_valid`=0 for 20 cycles in CHECK, then assert `reset`: `req_valid` drops immediately, and the board equals the start position on the next cycle.
